// File: rtl/systolic_array_ctrl.sv
// Sequencer for a 4x4 output-stationary int8 systolic array: clear, skewed operand feed, drain, result write-back.
// Latency: done arrives 1 + K + DRAIN_CYCLES + 4 + 1 cycles after an accepted start; edge operands are registered.
// Backpressure: none; buffers are assumed always ready, and start is ignored while busy.
module systolic_array_ctrl #(
    parameter int ARRAY_SIZE   = 4,
    parameter int ADDR_W       = 12,
    parameter int DRAIN_CYCLES = 9
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_start,
    input  logic [ADDR_W-1:0]   i_k_len,
    input  logic [ADDR_W-1:0]   i_a_base,
    input  logic [ADDR_W-1:0]   i_b_base,
    input  logic [ADDR_W-1:0]   i_c_base,
    input  logic signed [8:0]   i_input_offset,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_a_rd_en,
    output logic [ADDR_W-1:0]   o_a_addr,
    input  logic [31:0]         i_a_data,
    output logic                o_b_rd_en,
    output logic [ADDR_W-1:0]   o_b_addr,
    input  logic [31:0]         i_b_data,
    output logic                o_pe_rst,
    output logic signed [8:0]   o_left_0,
    output logic signed [8:0]   o_left_1,
    output logic signed [8:0]   o_left_2,
    output logic signed [8:0]   o_left_3,
    output logic signed [7:0]   o_top_0,
    output logic signed [7:0]   o_top_1,
    output logic signed [7:0]   o_top_2,
    output logic signed [7:0]   o_top_3,
    input  logic [127:0]        i_out_0,
    input  logic [127:0]        i_out_1,
    input  logic [127:0]        i_out_2,
    input  logic [127:0]        i_out_3,
    output logic                o_c_wr_en,
    output logic [ADDR_W-1:0]   o_c_addr,
    output logic [127:0]        o_c_data
);

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_FEED, S_DRAIN, S_WRITE, S_DONE
    } state_t;

    state_t              r_state, w_next;
    logic [ADDR_W-1:0]   r_cnt, w_cnt_nxt;
    logic [ADDR_W-1:0]   r_k, r_a_base, r_b_base, r_c_base;
    logic [8:0]          r_off;
    logic                r_rd_vld;
    logic [8:0]          w_left [ARRAY_SIZE];
    logic [7:0]          w_top  [ARRAY_SIZE];

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_k      <= '0;
            r_a_base <= '0;
            r_b_base <= '0;
            r_c_base <= '0;
            r_off    <= '0;
            r_rd_vld <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_cnt    <= w_cnt_nxt;
            r_rd_vld <= (r_state == S_FEED);
            if (r_state == S_IDLE && i_start) begin
                r_k      <= i_k_len;
                r_a_base <= i_a_base;
                r_b_base <= i_b_base;
                r_c_base <= i_c_base;
                r_off    <= i_input_offset;
            end
        end
    end

    always_comb begin
        w_next    = r_state;
        w_cnt_nxt = r_cnt;
        o_busy    = 1'b0;
        o_done    = 1'b0;
        o_a_rd_en = 1'b0;
        o_b_rd_en = 1'b0;
        o_a_addr  = '0;
        o_b_addr  = '0;
        o_pe_rst  = 1'b0;
        o_c_wr_en = 1'b0;
        o_c_addr  = '0;
        o_c_data  = '0;
        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                // A zero-depth command completes without touching the array or buffers.
                if (i_start) w_next = (i_k_len == '0) ? S_DONE : S_CLEAR;
            end
            S_CLEAR: begin
                o_busy   = 1'b1;
                o_pe_rst = 1'b1;
                w_next   = S_FEED;
            end
            S_FEED: begin
                o_busy    = 1'b1;
                o_a_rd_en = 1'b1;
                o_b_rd_en = 1'b1;
                o_a_addr  = r_a_base + r_cnt;
                o_b_addr  = r_b_base + r_cnt;
                if (r_cnt == r_k - ADDR_W'(1)) begin
                    w_next    = S_DRAIN;
                    w_cnt_nxt = '0;
                end else begin
                    w_cnt_nxt = r_cnt + ADDR_W'(1);
                end
            end
            S_DRAIN: begin
                o_busy = 1'b1;
                if (r_cnt == ADDR_W'(DRAIN_CYCLES - 1)) begin
                    w_next    = S_WRITE;
                    w_cnt_nxt = '0;
                end else begin
                    w_cnt_nxt = r_cnt + ADDR_W'(1);
                end
            end
            S_WRITE: begin
                o_busy    = 1'b1;
                o_c_wr_en = 1'b1;
                o_c_addr  = r_c_base + r_cnt;
                case (r_cnt[1:0])
                    2'd0:    o_c_data = i_out_0;
                    2'd1:    o_c_data = i_out_1;
                    2'd2:    o_c_data = i_out_2;
                    default: o_c_data = i_out_3;
                endcase
                if (r_cnt == ADDR_W'(ARRAY_SIZE - 1)) begin
                    w_next    = S_DONE;
                    w_cnt_nxt = '0;
                end else begin
                    w_cnt_nxt = r_cnt + ADDR_W'(1);
                end
            end
            S_DONE: begin
                o_done = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Row/column g gets a delay line of g+1 registers; empty slots carry zero, never the offset.
    for (genvar gi = 0; gi < ARRAY_SIZE; gi++) begin : g_skew
        logic [8:0] r_l [0:gi];
        logic [7:0] r_t [0:gi];
        logic [7:0] w_ab, w_bb;
        logic [8:0] w_lin;
        logic [7:0] w_tin;

        assign w_ab  = i_a_data[31-8*gi -: 8];
        assign w_bb  = i_b_data[31-8*gi -: 8];
        assign w_lin = r_rd_vld ? ({w_ab[7], w_ab} + r_off) : 9'd0;
        assign w_tin = r_rd_vld ? w_bb : 8'd0;

        always_ff @(posedge i_clk or negedge i_reset) begin
            if (!i_reset) begin
                for (int n = 0; n <= gi; n++) begin
                    r_l[n] <= '0;
                    r_t[n] <= '0;
                end
            end else begin
                r_l[0] <= w_lin;
                r_t[0] <= w_tin;
                for (int n = 1; n <= gi; n++) begin
                    r_l[n] <= r_l[n-1];
                    r_t[n] <= r_t[n-1];
                end
            end
        end

        assign w_left[gi] = r_l[gi];
        assign w_top[gi]  = r_t[gi];
    end

    assign o_left_0 = w_left[0];
    assign o_left_1 = w_left[1];
    assign o_left_2 = w_left[2];
    assign o_left_3 = w_left[3];
    assign o_top_0  = w_top[0];
    assign o_top_1  = w_top[1];
    assign o_top_2  = w_top[2];
    assign o_top_3  = w_top[3];

endmodule

// File: tb/tb_systolic_array_ctrl.sv
// Directed bench: buffer memories and a behavioural 4x4 output-stationary array around the sequencer.
module tb_systolic_array_ctrl;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               start = 1'b0;
    logic [11:0]        k_len = '0, a_base = '0, b_base = '0, c_base = '0;
    logic signed [8:0]  offset = '0;
    logic               busy, done, a_rd_en, b_rd_en, pe_rst, c_wr_en;
    logic [11:0]        a_addr, b_addr, c_addr;
    logic [31:0]        a_data = '0, b_data = '0;
    logic signed [8:0]  left_0, left_1, left_2, left_3;
    logic signed [7:0]  top_0, top_1, top_2, top_3;
    logic [127:0]       c_data;
    logic [127:0]       m_out [4];

    logic [31:0]  a_mem [4096];
    logic [31:0]  b_mem [4096];
    logic [127:0] c_mem [4096];

    int  errors = 0, checks = 0;
    int  rd_cnt = 0, wr_cnt = 0, done_cnt = 0, pe_cnt = 0, busy_cnt = 0, nzl_cnt = 0;
    logic m_clr = 1'b1;

    always #5 clk = ~clk;

    systolic_array_ctrl dut (
        .i_clk(clk), .i_reset(rst_n), .i_start(start), .i_k_len(k_len),
        .i_a_base(a_base), .i_b_base(b_base), .i_c_base(c_base), .i_input_offset(offset),
        .o_busy(busy), .o_done(done),
        .o_a_rd_en(a_rd_en), .o_a_addr(a_addr), .i_a_data(a_data),
        .o_b_rd_en(b_rd_en), .o_b_addr(b_addr), .i_b_data(b_data),
        .o_pe_rst(pe_rst),
        .o_left_0(left_0), .o_left_1(left_1), .o_left_2(left_2), .o_left_3(left_3),
        .o_top_0(top_0), .o_top_1(top_1), .o_top_2(top_2), .o_top_3(top_3),
        .i_out_0(m_out[0]), .i_out_1(m_out[1]), .i_out_2(m_out[2]), .i_out_3(m_out[3]),
        .o_c_wr_en(c_wr_en), .o_c_addr(c_addr), .o_c_data(c_data)
    );

    always @(posedge clk) begin
        if (a_rd_en) a_data <= a_mem[a_addr];
        if (b_rd_en) b_data <= b_mem[b_addr];
        if (c_wr_en) c_mem[c_addr] <= c_data;
        if (a_rd_en || b_rd_en) rd_cnt <= rd_cnt + 1;
        if (c_wr_en) wr_cnt <= wr_cnt + 1;
        if (done) done_cnt <= done_cnt + 1;
        if (pe_rst) pe_cnt <= pe_cnt + 1;
        if (busy) busy_cnt <= busy_cnt + 1;
        if (left_0 != 0 || left_1 != 0 || left_2 != 0 || left_3 != 0) nzl_cnt <= nzl_cnt + 1;
    end

    int lv [4], tv [4];
    always_comb begin
        lv[0] = left_0; lv[1] = left_1; lv[2] = left_2; lv[3] = left_3;
        tv[0] = top_0;  tv[1] = top_1;  tv[2] = top_2;  tv[3] = top_3;
    end

    // Behavioural array: A moves right, B moves down, each PE accumulates a*b; outputs registered once more.
    int m_a [4][4], m_b [4][4], m_acc [4][4];
    always @(posedge clk) begin
        int ain, bin;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                ain = (j == 0) ? lv[i] : m_a[i][j-1];
                bin = (i == 0) ? tv[j] : m_b[i-1][j];
                m_a[i][j] <= m_clr ? 0 : ain;
                m_b[i][j] <= m_clr ? 0 : bin;
                m_acc[i][j] <= (m_clr || pe_rst) ? 0 : m_acc[i][j] + ain * bin;
            end
            m_out[i] <= {m_acc[i][0], m_acc[i][1], m_acc[i][2], m_acc[i][3]};
        end
    end

    function automatic logic [127:0] p4(input int a, input int b, input int c, input int d);
        return {a, b, c, d};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issues one command; inputs are scrambled after start to show they were latched.
    task automatic run(input logic [11:0] k, input logic [11:0] ab, input logic [11:0] bb,
                       input logic [11:0] cb, input logic [8:0] off, input int repulse_at,
                       output int lat, output logic b1, output logic p1);
        @(negedge clk);
        k_len = k; a_base = ab; b_base = bb; c_base = cb; offset = off; start = 1'b1;
        lat = 0; b1 = 1'b0; p1 = 1'b0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                start = 1'b0; k_len = 12'hfff; a_base = 12'h555; b_base = 12'h666;
                c_base = 12'h777; offset = 9'h1ff; b1 = busy; p1 = pe_rst;
            end
            if (lat == repulse_at) begin start = 1'b1; k_len = 12'd7; end
            if (lat == repulse_at + 1) start = 1'b0;
        end while (!done && lat < 300);
        if (lat >= 300) chk("done_timeout", 128'(lat), 128'(0));
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int lat, rd0, wr0, dn0, pe0, bz0, nz0;
        logic b1, p1;

        for (int i = 0; i < 4096; i++) begin
            a_mem[i] = '0; b_mem[i] = '0; c_mem[i] = '1;
        end

        repeat (3) @(negedge clk);
        chk("reset_ctrl", {busy, done, a_rd_en, b_rd_en, pe_rst, c_wr_en, a_addr, b_addr, c_addr}, '0);
        chk("reset_edges", {left_0, left_1, left_2, left_3, top_0, top_1, top_2, top_3}, '0);
        chk("reset_cdata", c_data, '0);
        m_clr = 1'b0;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // K=1 broadcast: row i of C is four copies of A row i.
        a_mem[10] = 32'h01020304; b_mem[20] = 32'h01010101;
        rd0 = rd_cnt; wr0 = wr_cnt;
        run(12'd1, 12'd10, 12'd20, 12'd30, 9'd0, -1, lat, b1, p1);
        chk("k1_latency", 128'(lat), 128'(16));
        chk("k1_busy_clear", {126'd0, b1, p1}, 128'b11);
        chk("k1_c0", c_mem[30], p4(1, 1, 1, 1));
        chk("k1_c1", c_mem[31], p4(2, 2, 2, 2));
        chk("k1_c2", c_mem[32], p4(3, 3, 3, 3));
        chk("k1_c3", c_mem[33], p4(4, 4, 4, 4));
        chk("k1_reads", 128'(rd_cnt - rd0), 128'(1));
        chk("k1_writes", 128'(wr_cnt - wr0), 128'(4));

        // K=4 identity x B, bases straddling the address wrap.
        for (int k = 0; k < 4; k++) begin
            a_mem[(4094 + k) % 4096] = 32'h01000000 >> (8 * k);
            b_mem[(4094 + k) % 4096] = {8'(4*k+1), 8'(4*k+2), 8'(4*k+3), 8'(4*k+4)};
        end
        wr0 = wr_cnt;
        run(12'd4, 12'd4094, 12'd4094, 12'd4094, 9'd0, -1, lat, b1, p1);
        chk("id_latency", 128'(lat), 128'(19));
        chk("id_c0", c_mem[4094], p4(1, 2, 3, 4));
        chk("id_c1", c_mem[4095], p4(5, 6, 7, 8));
        chk("id_c2", c_mem[0], p4(9, 10, 11, 12));
        chk("id_c3", c_mem[1], p4(13, 14, 15, 16));
        chk("id_writes", 128'(wr_cnt - wr0), 128'(4));

        // Offset cancels -128 exactly; the edge must stay at zero throughout, pad slots included.
        a_mem[40] = 32'h80808080; a_mem[41] = 32'h80808080;
        b_mem[50] = 32'h01010101; b_mem[51] = 32'h01010101;
        nz0 = nzl_cnt;
        run(12'd2, 12'd40, 12'd50, 12'd60, 9'd128, -1, lat, b1, p1);
        chk("ofs_left_nonzero", 128'(nzl_cnt - nz0), 128'(0));
        chk("ofs_c0", c_mem[60], '0);
        chk("ofs_c3", c_mem[63], '0);

        // Signed operands with a positive offset: left = 4, 3, 7, -123; top = 3, -3, 1, 2.
        a_mem[70] = 32'hFFFE0280; b_mem[80] = 32'h03FD0102;
        run(12'd1, 12'd70, 12'd80, 12'd90, 9'd5, -1, lat, b1, p1);
        chk("sgn_c0", c_mem[90], p4(12, -12, 4, 8));
        chk("sgn_c1", c_mem[91], p4(9, -9, 3, 6));
        chk("sgn_c3", c_mem[93], p4(-369, 369, -123, -246));

        // Zero-depth command.
        rd0 = rd_cnt; wr0 = wr_cnt; pe0 = pe_cnt; bz0 = busy_cnt; dn0 = done_cnt;
        run(12'd0, 12'd0, 12'd0, 12'd0, 9'd0, -1, lat, b1, p1);
        chk("k0_latency", 128'(lat), 128'(1));
        chk("k0_activity", {32'(rd_cnt - rd0), 32'(wr_cnt - wr0), 32'(pe_cnt - pe0), 32'(busy_cnt - bz0)}, '0);
        chk("k0_done_count", 128'(done_cnt - dn0), 128'(1));

        // start re-pulsed during FEED with another depth is ignored.
        rd0 = rd_cnt; dn0 = done_cnt;
        run(12'd3, 12'd100, 12'd100, 12'd120, 9'd0, 3, lat, b1, p1);
        chk("rep_latency", 128'(lat), 128'(18));
        chk("rep_reads", 128'(rd_cnt - rd0), 128'(3));
        chk("rep_done_count", 128'(done_cnt - dn0), 128'(1));
        repeat (20) @(negedge clk);
        chk("rep_no_restart", 128'(rd_cnt - rd0), 128'(3));

        // Reset at FEED f=2 of a K=8 command aborts immediately and silently.
        for (int k = 0; k < 8; k++) begin
            a_mem[300 + k] = 32'h7F7F7F7F; b_mem[300 + k] = 32'h7F7F7F7F;
        end
        @(negedge clk);
        k_len = 12'd8; a_base = 12'd300; b_base = 12'd300; c_base = 12'd400; offset = '0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort_in_feed", {127'd0, a_rd_en}, 128'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_ctrl", {busy, done, a_rd_en, b_rd_en, pe_rst, c_wr_en, a_addr, b_addr, c_addr}, '0);
        chk("abort_edges", {left_0, left_1, left_2, left_3, top_0, top_1, top_2, top_3}, '0);
        chk("abort_cdata", c_data, '0);
        rd0 = rd_cnt; wr0 = wr_cnt; dn0 = done_cnt;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (25) @(negedge clk);
        chk("abort_silent", {32'(rd_cnt - rd0), 32'(wr_cnt - wr0), 32'(done_cnt - dn0), 32'd0}, '0);

        a_mem[200] = 32'h05060708; b_mem[210] = 32'h01010101;
        run(12'd1, 12'd200, 12'd210, 12'd220, 9'd0, -1, lat, b1, p1);
        chk("post_latency", 128'(lat), 128'(16));
        chk("post_c0", c_mem[220], p4(5, 5, 5, 5));
        chk("post_c3", c_mem[223], p4(8, 8, 8, 8));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/systolic_array_ctrl.md
Name: systolic_array_ctrl

Overview:
Sequencer for the 4x4 output-stationary int8 systolic array.
- On `start`, clears the PE accumulators.
- Streams K columns of A and K rows of B from the operand buffers into the array's left/top edges with the required diagonal skew and input offset.
- Waits for the array to drain, then writes the four 128-bit result rows into the C buffer.
- Sits between the CFU command decoder (start/done) and the array plus its A/B/C global buffers.

Parameters:
ARRAY_SIZE, 4, array dimension; fixed at 4, others unsupported.
ADDR_W, 12, buffer address width.
DRAIN_CYCLES, 9, cycles from last FEED cycle until array outputs are final (1 rd latency + 3 skew + 3 propagation + 1 PE acc + 1 out reg).

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  one-cycle command pulse, sampled in IDLE only
k_len  in  ADDR_W  reduction depth K
a_base  in  ADDR_W  A buffer start address
b_base  in  ADDR_W  B buffer start address
c_base  in  ADDR_W  C buffer start address
input_offset  in  9 signed  added to every A operand
busy  out  1  high from accepted start until done
done  out  1  one-cycle completion pulse
a_rd_en  out  1  A buffer read strobe
a_addr  out  ADDR_W  A read address
a_data  in  32  A word: [31:24] row0, [23:16] row1, [15:8] row2, [7:0] row3; valid 1 cycle after a_rd_en
b_rd_en  out  1  B buffer read strobe
b_addr  out  ADDR_W  B read address
b_data  in  32  B word: [31:24] col0 … [7:0] col3; 1-cycle latency
PE_rst  out  1  synchronous accumulator clear to array, active high
left_0..left_3  out  9 signed  array left edge
top_0..top_3  out  8 signed  array top edge
out_0..out_3  in  128  array result rows
c_wr_en  out  1  C buffer write strobe
c_addr  out  ADDR_W  C write address
c_data  out  128  C write data

Behaviour:
- Reset (async, reset=0):
  - State goes to IDLE.
  - Counters and skew registers are cleared.
  - All outputs are 0: busy, done, rd/wr strobes, addresses, PE_rst, left/top, c_data.
  - Reset asserted mid-operation aborts immediately. No further reads or writes occur, and done is not pulsed.
- States:
  - IDLE:
    - start=1 and k_len!=0: go to CLEAR, busy=1.
    - start=1 and k_len==0: done pulses next cycle, busy stays 0, no reads or writes.
  - CLEAR: PE_rst=1 for exactly 1 cycle, then FEED.
  - FEED:
    - Lasts K cycles, f=0..K-1.
    - a_rd_en=b_rd_en=1, a_addr=a_base+f, b_addr=b_base+f.
    - Then DRAIN.
  - DRAIN: counts DRAIN_CYCLES cycles with no reads, then WRITE.
  - WRITE:
    - 4 cycles, r=0..3.
    - c_wr_en=1, c_addr=c_base+r, c_data=out_r sampled the same cycle.
    - Then DONE.
  - DONE: done=1 for 1 cycle, busy drops the same cycle, then IDLE.
- Skew:
  - Returned word k enters the skew stage the cycle after its read.
  - Row i byte is delayed i additional cycles before driving left_i; column j byte is delayed j cycles before driving top_j.
  - Slots holding no valid operand (before the first or after the last) drive left_i=0 and top_j=0, never the offset.
- Arithmetic:
  - left_i = sign-extend(A byte to 9b) + input_offset, two's complement 9-bit.
  - Range -256..254 holds for offsets -128..127; other offsets wrap and are out of spec.
  - top_j = B byte unchanged.
- Edge outputs are registered; left/top are 0 outside FEED/DRAIN.
- start while busy is ignored. k_len, bases and offset are latched at start; later changes have no effect.
- Address arithmetic wraps modulo 2^ADDR_W.
- Total latency from start to done = 1 + K + DRAIN_CYCLES + 4 + 1 cycles.

Test Plan:
- K=1, a_data=0x01020304, b_data=0x01010101, offset=0 -> C rows 0..3 each hold 4 copies of 1, 2, 3, 4 respectively; done 16 cycles after start.
- K=4, A=identity bytes, B=bytes 1..16 row-major, offset=0 -> C equals B row-major as 32-bit words; exactly 4 c_wr_en pulses at c_base..c_base+3.
- K=2, all A bytes 0x80 (-128), B bytes 0x01, offset=+128 -> every result 0; left_i never exceeds 9-bit range; pad slots are 0, not 128.
- k_len=0 with start -> done one cycle later; no a_rd_en, b_rd_en, PE_rst or c_wr_en.
- start re-pulsed during FEED with different k_len -> ignored; original K reads only; single done.
- Reset deasserted→asserted at FEED f=2 with K=8 -> all outputs 0 within the same cycle; after release a new start with K=1 produces correct results with accumulators cleared.
